// File: rtl/bitmask_slot_allocator_pkg.sv
// rtl/bitmask_slot_allocator_pkg.sv - shared helpers for the bitmask slot allocator
package bitmask_slot_allocator_pkg;

  localparam int MAX_SLOTS = 64;
  localparam logic [MAX_SLOTS-1:0] ONE = {{(MAX_SLOTS-1){1'b0}}, 1'b1};

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // An all-zero input encodes to index 0.
  function automatic logic [31:0] onehot_to_index(input logic [MAX_SLOTS-1:0] onehot);
    logic [31:0] index;
    index = '0;
    for (int i = 0; i < MAX_SLOTS; i++) begin
      if (onehot[i]) index = index | 32'(i);
    end
    return index;
  endfunction

endpackage

// File: rtl/bitmask_slot_allocator_isolate.sv
// rtl/bitmask_slot_allocator_isolate.sv - one-hot of the lowest clear bit of a word
module bitmask_isolate_rightmost_0_bit
  import bitmask_slot_allocator_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] word_in,
  output logic [WIDTH-1:0] word_out
);

  // An all-ones word carries out of the add, leaving zero.
  assign word_out = ~word_in & (word_in + WIDTH'(ONE));

endmodule

// File: rtl/bitmask_slot_allocator.sv
// rtl/bitmask_slot_allocator.sv - lowest-free-first slot allocator over a busy bitmap
// Optional sticky error detection: BITMASK_SLOT_ALLOCATOR_ERROR_CHECK_EN.
module bitmask_slot_allocator
  import bitmask_slot_allocator_pkg::*;
#(
  parameter int SLOT_COUNT  = 8,
  parameter int INDEX_WIDTH = clog2(SLOT_COUNT),
  parameter int COUNT_WIDTH = clog2(SLOT_COUNT + 1)
) (
  input  logic                   clock,
  input  logic                   clear_n,
  input  logic                   alloc_valid,
  output logic                   alloc_ready,
  output logic [INDEX_WIDTH-1:0] alloc_index,
  output logic [SLOT_COUNT-1:0]  alloc_onehot,
  input  logic                   free_valid,
  input  logic [INDEX_WIDTH-1:0] free_index,
  output logic [SLOT_COUNT-1:0]  busy_bitmap,
  output logic [COUNT_WIDTH-1:0] busy_count,
  output logic                   all_busy,
  output logic                   error
);

  logic                   alloc_fire;
  logic                   free_in_range;
  logic                   free_legal;
  logic [SLOT_COUNT-1:0]  busy_next;
  logic [COUNT_WIDTH-1:0] count_next;

  bitmask_isolate_rightmost_0_bit #(.WIDTH(SLOT_COUNT)) u_isolate (
    .word_in  (busy_bitmap),
    .word_out (alloc_onehot)
  );

  assign all_busy    = &busy_bitmap;
  assign alloc_ready = clear_n & ~all_busy;
  assign alloc_index = INDEX_WIDTH'(onehot_to_index(MAX_SLOTS'(alloc_onehot)));
  assign alloc_fire  = alloc_valid & alloc_ready;

  generate
    if (SLOT_COUNT == (1 << INDEX_WIDTH)) begin : g_full_range
      assign free_in_range = 1'b1;
    end else begin : g_partial_range
      localparam logic [INDEX_WIDTH:0] SLOT_LIMIT = (INDEX_WIDTH + 1)'(SLOT_COUNT);
      assign free_in_range = {1'b0, free_index} < SLOT_LIMIT;
    end
  endgenerate

  // A free naming the slot offered this cycle is not busy, so it is illegal and the allocate wins.
  assign free_legal = free_valid & free_in_range & busy_bitmap[free_index];

  always_comb begin
    busy_next = busy_bitmap;
    if (free_legal) busy_next[free_index] = 1'b0;
    if (alloc_fire) busy_next = busy_next | alloc_onehot;
  end

  always_comb begin
    count_next = busy_count;
    unique case ({alloc_fire, free_legal})
      2'b10:   count_next = busy_count + COUNT_WIDTH'(1);
      2'b01:   count_next = busy_count - COUNT_WIDTH'(1);
      default: count_next = busy_count;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      busy_bitmap <= '0;
      busy_count  <= '0;
    end else begin
      busy_bitmap <= busy_next;
      busy_count  <= count_next;
    end
  end

`ifdef BITMASK_SLOT_ALLOCATOR_ERROR_CHECK_EN
  logic error_next;

  assign error_next = error
                    | (free_valid & ~free_legal)
                    | (alloc_valid & ~alloc_ready & all_busy);

  always_ff @(posedge clock) begin
    if (!clear_n) error <= 1'b0;
    else          error <= error_next;
  end
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_bitmask_slot_allocator.sv
// tb/tb_bitmask_slot_allocator.sv - self-checking bench for bitmask_slot_allocator (SLOT_COUNT=4)
module tb_bitmask_slot_allocator;

  localparam int N = 4;

  logic       clock;
  logic       clear_n;
  logic       alloc_valid;
  logic       alloc_ready;
  logic [1:0] alloc_index;
  logic [3:0] alloc_onehot;
  logic       free_valid;
  logic [1:0] free_index;
  logic [3:0] busy_bitmap;
  logic [2:0] busy_count;
  logic       all_busy;
  logic       error;

  int checks   = 0;
  int failures = 0;

  // Reference state: per-slot busy flags and a sticky error flag.
  bit m_busy[N];
  bit m_err;
  bit m_known;

  bitmask_slot_allocator #(.SLOT_COUNT(N)) dut (
    .clock        (clock),
    .clear_n      (clear_n),
    .alloc_valid  (alloc_valid),
    .alloc_ready  (alloc_ready),
    .alloc_index  (alloc_index),
    .alloc_onehot (alloc_onehot),
    .free_valid   (free_valid),
    .free_index   (free_index),
    .busy_bitmap  (busy_bitmap),
    .busy_count   (busy_count),
    .all_busy     (all_busy),
    .error        (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int m_lowest_free();
    for (int i = 0; i < N; i++) if (!m_busy[i]) return i;
    return -1;
  endfunction

  function automatic logic [3:0] m_vec();
    logic [3:0] v;
    for (int i = 0; i < N; i++) v[i] = m_busy[i];
    return v;
  endfunction

  function automatic int m_pop();
    int c = 0;
    for (int i = 0; i < N; i++) c += m_busy[i];
    return c;
  endfunction

  task automatic check_state();
    bit exp_err;
`ifdef BITMASK_SLOT_ALLOCATOR_ERROR_CHECK_EN
    exp_err = m_err;
`else
    exp_err = 1'b0;
`endif
    chk("busy_bitmap", 32'(busy_bitmap), 32'(m_vec()));
    chk("busy_count", 32'(busy_count), 32'(m_pop()));
    chk("all_busy", 32'(all_busy), 32'(m_pop() == N));
    chk("error", 32'(error), 32'(exp_err));
  endtask

  // Drive one cycle, check the combinational offer before the edge, then the registered state after it.
  task automatic cycle(input bit av, input bit fv, input int fi, input bit cn);
    int  low;
    bit  full;
    bit  legal;
    alloc_valid = av;
    free_valid  = fv;
    free_index  = 2'(fi);
    clear_n     = cn;
    #1;
    low  = m_lowest_free();
    full = (low < 0);
    if (m_known) begin
      chk("alloc_ready", 32'(alloc_ready), 32'(cn && !full));
      chk("alloc_index", 32'(alloc_index), full ? 32'd0 : 32'(low));
      chk("alloc_onehot", 32'(alloc_onehot), full ? 32'd0 : (32'd1 << low));
    end
    if (!cn) begin
      for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
      m_err   = 1'b0;
      m_known = 1'b1;
    end else begin
      legal = fv && m_busy[fi];
      if ((fv && !legal) || (av && full)) m_err = 1'b1;
      if (legal) m_busy[fi] = 1'b0;
      if (av && !full) m_busy[low] = 1'b1;
    end
    @(posedge clock);
    #1;
    if (m_known) check_state();
  endtask

  initial begin
    alloc_valid = 1'b0;
    free_valid  = 1'b0;
    free_index  = '0;
    clear_n     = 1'b0;
    m_known     = 1'b0;
    m_err       = 1'b0;
    @(posedge clock);
    #1;

    // Reset then idle.
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    chk("idle_onehot", 32'(alloc_onehot), 32'h1);
    chk("idle_ready", 32'(alloc_ready), 32'h1);

    // Fill with a held request; the fifth is refused.
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 1);
    chk("full_bitmap", 32'(busy_bitmap), 32'hf);
    chk("full_count", 32'(busy_count), 32'd4);
    chk("full_ready", 32'(alloc_ready), 32'h0);

    // Free slot 2 from full.
    cycle(0, 1, 2, 1);
    chk("free2_bitmap", 32'(busy_bitmap), 32'hb);
    chk("free2_index", 32'(alloc_index), 32'd2);
    chk("free2_onehot", 32'(alloc_onehot), 32'h4);

    // Simultaneous allocate and free from 0011.
    cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 1);
    cycle(1, 0, 0, 1);
    cycle(1, 1, 0, 1);
    chk("swap_bitmap", 32'(busy_bitmap), 32'h6);
    chk("swap_count", 32'(busy_count), 32'd2);
    chk("swap_index", 32'(alloc_index), 32'd0);

    // Double free of a non-busy slot from 0001.
    cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 1);
    cycle(0, 1, 3, 1);
    chk("dfree_bitmap", 32'(busy_bitmap), 32'h1);
    chk("dfree_count", 32'(busy_count), 32'd1);

    // Free of the slot being allocated in the same cycle: allocate wins.
    cycle(1, 1, 1, 1);
    chk("same_slot_bitmap", 32'(busy_bitmap), 32'h3);

    // Mid-run reset from 1011 with a request pending.
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 1);
    cycle(0, 1, 2, 1);
    cycle(1, 0, 0, 0);
    chk("rst_bitmap", 32'(busy_bitmap), 32'h0);
    chk("rst_count", 32'(busy_count), 32'd0);
    cycle(0, 0, 0, 1);

    // Random traffic, mostly legal frees with occasional illegal ones and resets.
    for (int n = 0; n < 400; n++) begin
      bit av, fv, cn;
      int fi;
      av = ($urandom_range(0, 99) < 55);
      fv = ($urandom_range(0, 99) < 45);
      fi = $urandom_range(0, N - 1);
      cn = ($urandom_range(0, 99) != 0);
      cycle(av, fv, fi, cn);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
